// File: rtl/id_stage.sv
`default_nettype none
// ============================================================================
//  Module   : id_stage
//  Purpose  : RV32I instruction-decode stage. Drives register-file read
//             addresses, bypasses MEM/WB results onto the operands, stalls
//             on RAW hazards against EX, decodes immediates and control,
//             and registers the result into the ID/EX pipeline register.
//  Revision : 1.0  initial release
// ============================================================================
module id_stage #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,

  // IF/ID side
  input  logic            if_valid,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  output logic            id_ready,
  input  logic            flush,

  // Register-file read port
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,

  // Hazard / bypass sources
  input  logic [4:0]      ex_hold_rd,
  input  logic            ex_hold_wen,
  input  logic            mem_wen,
  input  logic [4:0]      mem_rd,
  input  logic [XLEN-1:0] mem_value,
  input  logic            wb_wen,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_value,

  // ID/EX register
  input  logic            ex_ready,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_val,
  output logic [XLEN-1:0] ex_rs2_val,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rd,
  output logic [2:0]      ex_funct3,
  output logic            ex_funct7b5,
  output logic [6:0]      ex_opcode,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_branch,
  output logic            ex_jump,
  output logic            ex_illegal
);

  // Supported major opcodes. The low two bits are part of the match, so a
  // compressed-encoding word (instr[1:0] != 2'b11) falls into "illegal".
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // --------------------------------------------------------------------------
  // Instruction fields
  // --------------------------------------------------------------------------
  logic [6:0] w_opcode;
  logic [4:0] w_rd;
  logic [2:0] w_funct3;
  logic [4:0] w_rs1;
  logic [4:0] w_rs2;

  assign w_opcode = if_instr[6:0];
  assign w_rd     = if_instr[11:7];
  assign w_funct3 = if_instr[14:12];
  assign w_rs1    = if_instr[19:15];
  assign w_rs2    = if_instr[24:20];

  assign rs1_addr = w_rs1;
  assign rs2_addr = w_rs2;

  // --------------------------------------------------------------------------
  // Immediate formats, each already sign-extended to 32 bits from instr[31]
  // --------------------------------------------------------------------------
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_s;
  logic [31:0] w_imm_b;
  logic [31:0] w_imm_u;
  logic [31:0] w_imm_j;

  assign w_imm_i = {{20{if_instr[31]}}, if_instr[31:20]};
  assign w_imm_s = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
  assign w_imm_b = {{19{if_instr[31]}}, if_instr[31], if_instr[7],
                    if_instr[30:25], if_instr[11:8], 1'b0};
  assign w_imm_u = {if_instr[31:12], 12'h000};
  assign w_imm_j = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12],
                    if_instr[20], if_instr[30:21], 1'b0};

  // --------------------------------------------------------------------------
  // Decode
  // --------------------------------------------------------------------------
  logic signed [31:0] w_imm32;
  logic [XLEN-1:0]    w_imm;
  logic               w_use_rs1;
  logic               w_use_rs2;
  logic               w_reg_write;
  logic               w_mem_read;
  logic               w_mem_write;
  logic               w_branch;
  logic               w_jump;
  logic               w_illegal;

  // Opcode decode: operand usage, immediate selection and control bits.
  always_comb begin
    w_imm32     = '0;
    w_use_rs1   = 1'b1;
    w_use_rs2   = 1'b0;
    w_reg_write = 1'b0;
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    w_branch    = 1'b0;
    w_jump      = 1'b0;
    w_illegal   = 1'b0;
    case (w_opcode)
      OPC_LOAD: begin
        w_imm32     = w_imm_i;
        w_mem_read  = 1'b1;
        w_reg_write = 1'b1;
      end
      OPC_OPIMM: begin
        w_imm32     = w_imm_i;
        w_reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        w_imm32     = w_imm_u;
        w_use_rs1   = 1'b0;
        w_reg_write = 1'b1;
      end
      OPC_STORE: begin
        w_imm32     = w_imm_s;
        w_use_rs2   = 1'b1;
        w_mem_write = 1'b1;
      end
      OPC_OP: begin
        w_use_rs2   = 1'b1;
        w_reg_write = 1'b1;
      end
      OPC_LUI: begin
        w_imm32     = w_imm_u;
        w_use_rs1   = 1'b0;
        w_reg_write = 1'b1;
      end
      OPC_BRANCH: begin
        w_imm32     = w_imm_b;
        w_use_rs2   = 1'b1;
        w_branch    = 1'b1;
      end
      OPC_JALR: begin
        w_imm32     = w_imm_i;
        w_jump      = 1'b1;
        w_reg_write = 1'b1;
      end
      OPC_JAL: begin
        w_imm32     = w_imm_j;
        w_use_rs1   = 1'b0;
        w_jump      = 1'b1;
        w_reg_write = 1'b1;
      end
      default: begin
        w_illegal   = 1'b1;
      end
    endcase
    // Writes to x0 are architecturally discarded; drop them here so
    // downstream never has to look at rd.
    if (w_rd == 5'd0) begin
      w_reg_write = 1'b0;
    end
  end

  assign w_imm = XLEN'(w_imm32);

  // --------------------------------------------------------------------------
  // RAW hazard against EX. No EX->ID bypass exists, so any match stalls.
  // --------------------------------------------------------------------------
  logic w_rs1_hit;
  logic w_rs2_hit;
  logic w_hazard;

  assign w_rs1_hit = w_use_rs1 && (w_rs1 == ex_hold_rd);
  assign w_rs2_hit = w_use_rs2 && (w_rs2 == ex_hold_rd);
  assign w_hazard  = if_valid && ex_hold_wen && (ex_hold_rd != 5'd0) &&
                     (w_rs1_hit || w_rs2_hit);

  assign id_ready  = ex_ready && !w_hazard;

  // --------------------------------------------------------------------------
  // Operand bypass: x0, then MEM (younger), then WB, then register file.
  // WB must be checked because the register file write lands on the same
  // edge that this stage samples its read data.
  // --------------------------------------------------------------------------
  function automatic logic [XLEN-1:0] bypass(
    input logic [4:0]      addr,
    input logic [XLEN-1:0] rf_val,
    input logic            m_en,
    input logic [4:0]      m_rd,
    input logic [XLEN-1:0] m_val,
    input logic            b_en,
    input logic [4:0]      b_rd,
    input logic [XLEN-1:0] b_val
  );
    logic [XLEN-1:0] result;
    if (addr == 5'd0) begin
      result = '0;
    end else if (m_en && (m_rd == addr)) begin
      result = m_val;
    end else if (b_en && (b_rd == addr)) begin
      result = b_val;
    end else begin
      result = rf_val;
    end
    return result;
  endfunction

  logic [XLEN-1:0] w_rs1_val;
  logic [XLEN-1:0] w_rs2_val;

  assign w_rs1_val = bypass(w_rs1, rs1_data, mem_wen, mem_rd, mem_value,
                            wb_wen, wb_rd, wb_value);
  assign w_rs2_val = bypass(w_rs2, rs2_data, mem_wen, mem_rd, mem_value,
                            wb_wen, wb_rd, wb_value);

  // --------------------------------------------------------------------------
  // ID/EX pipeline register
  // --------------------------------------------------------------------------
  // Priority: reset, flush, back-pressure hold, bubble on hazard, load.
  // An empty IF/ID slot loads with all control bits cleared.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid     <= 1'b0;
      ex_pc        <= RESET_PC;
      ex_rs1_val   <= '0;
      ex_rs2_val   <= '0;
      ex_imm       <= '0;
      ex_rd        <= 5'd0;
      ex_funct3    <= 3'd0;
      ex_funct7b5  <= 1'b0;
      ex_opcode    <= 7'd0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_branch    <= 1'b0;
      ex_jump      <= 1'b0;
      ex_illegal   <= 1'b0;
    end else if (flush) begin
      ex_valid     <= 1'b0;
    end else if (ex_ready) begin
      if (w_hazard) begin
        ex_valid     <= 1'b0;
        ex_reg_write <= 1'b0;
        ex_mem_read  <= 1'b0;
        ex_mem_write <= 1'b0;
        ex_branch    <= 1'b0;
        ex_jump      <= 1'b0;
        ex_illegal   <= 1'b0;
      end else begin
        ex_valid     <= if_valid;
        ex_pc        <= if_pc;
        ex_rs1_val   <= w_rs1_val;
        ex_rs2_val   <= w_rs2_val;
        ex_imm       <= w_imm;
        ex_rd        <= w_rd;
        ex_funct3    <= w_funct3;
        ex_funct7b5  <= if_instr[30];
        ex_opcode    <= w_opcode;
        ex_reg_write <= if_valid && w_reg_write;
        ex_mem_read  <= if_valid && w_mem_read;
        ex_mem_write <= if_valid && w_mem_write;
        ex_branch    <= if_valid && w_branch;
        ex_jump      <= if_valid && w_jump;
        ex_illegal   <= if_valid && w_illegal;
      end
    end
  end

endmodule
`default_nettype wire
